// File: rtl/ecc_enc_top.sv
// SEC-DED (39,32) protected 1024x32 SRAM wrapper.
// Port 1: CE1/CSB1/OEB1/A1 -> O1. Port 2: CE2/CSB2/WEB2/A2/I2. Flags SEC_ERR/DED_ERR.
module ecc_enc_top #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CE1,
  input  logic          CSB1,
  input  logic          OEB1,
  input  logic [AW-1:0] A1,
  output logic [DW-1:0] O1,
  input  logic          CE2,
  input  logic          CSB2,
  input  logic          WEB2,
  input  logic [AW-1:0] A2,
  input  logic [DW-1:0] I2,
  input  logic [38:0]   ERR_INJ,
  output logic          SEC_ERR,
  output logic          DED_ERR
);

  localparam int DEPTH = 2 ** AW;

  // Stored word: bit p-1 holds Hamming position p (1..38),
  // bit 38 holds overall parity.
  function automatic logic [38:0] hm_enc(
    input logic [31:0] d
  );
    logic [38:1] h;
    logic        par;
    int          k;
    h = '0;
    k = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        h[p[5:0]] = d[k[4:0]];
        k++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      par = 1'b0;
      for (int p = 1; p <= 38; p++) begin
        if (((p & (1 << i)) != 0) && ((p & (p - 1)) != 0))
          par = par ^ h[p[5:0]];
      end
      h[6'(1 << i)] = par;
    end
    return {^h, h};
  endfunction

  // Returns {ded, sec, data}.
  function automatic logic [33:0] hm_dec(
    input logic [38:0] cw
  );
    logic [38:1] h;
    logic [5:0]  s;
    logic        par;
    logic        sec;
    logic        ded;
    logic [31:0] d;
    int          k;
    h   = cw[37:0];
    s   = '0;
    par = ^cw;
    sec = 1'b0;
    ded = 1'b0;
    d   = '0;
    k   = 0;
    for (int p = 1; p <= 38; p++) begin
      if (h[p[5:0]])
        s = s ^ p[5:0];
    end
    if (s == 6'd0 && !par) begin
      sec = 1'b0;
    end else if (par && s <= 6'd38) begin
      // s == 0 means the overall bit itself flipped
      sec = 1'b1;
      if (s != 6'd0)
        h[s] = ~h[s];
    end else begin
      ded = 1'b1;
    end
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k[4:0]] = h[p[5:0]];
        k++;
      end
    end
    return {ded, sec, d};
  endfunction

  logic [38:0]   mem [DEPTH];

  logic          ce1_q;
  logic          ce2_q;
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;
  logic          sec_q;
  logic          sec_d;
  logic          ded_q;
  logic          ded_d;

  logic          rd_en;
  logic          wr_en;
  logic [33:0]   dec_w;

  assign rd_en = CE1 & ~ce1_q & ~CSB1;
  assign wr_en = CE2 & ~ce2_q & ~CSB2 & ~WEB2 & rst_n;

  always_comb begin
    dec_w   = hm_dec(mem[A1]);
    rdata_d = rdata_q;
    sec_d   = sec_q;
    ded_d   = ded_q;
    if (rd_en) begin
      rdata_d = dec_w[31:0];
      sec_d   = dec_w[32];
      ded_d   = dec_w[33];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce1_q   <= 1'b0;
      ce2_q   <= 1'b0;
      rdata_q <= '0;
      sec_q   <= 1'b0;
      ded_q   <= 1'b0;
    end else begin
      ce1_q   <= CE1;
      ce2_q   <= CE2;
      rdata_q <= rdata_d;
      sec_q   <= sec_d;
      ded_q   <= ded_d;
    end
  end

  // Array is not reset; read path above sees old
  // contents on a same-edge write.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[A2] <= hm_enc(I2) ^ ERR_INJ;
  end

  assign O1      = OEB1 ? '0 : rdata_q;
  assign SEC_ERR = sec_q;
  assign DED_ERR = ded_q;

endmodule

// File: tb/tb_ecc_enc_top.sv
// Directed bench for ecc_enc_top.
// Hand-computed vectors, inline checks per scenario.
module tb_ecc_enc_top;

  logic        clk;
  logic        rst_n;
  logic        CE1;
  logic        CSB1;
  logic        OEB1;
  logic [9:0]  A1;
  logic [31:0] O1;
  logic        CE2;
  logic        CSB2;
  logic        WEB2;
  logic [9:0]  A2;
  logic [31:0] I2;
  logic [38:0] ERR_INJ;
  logic        SEC_ERR;
  logic        DED_ERR;

  int pass_cnt;
  int total_cnt;

  ecc_enc_top dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .CE1     (CE1),
    .CSB1    (CSB1),
    .OEB1    (OEB1),
    .A1      (A1),
    .O1      (O1),
    .CE2     (CE2),
    .CSB2    (CSB2),
    .WEB2    (WEB2),
    .A2      (A2),
    .I2      (I2),
    .ERR_INJ (ERR_INJ),
    .SEC_ERR (SEC_ERR),
    .DED_ERR (DED_ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(
    input logic [9:0]  a,
    input logic [31:0] d,
    input logic [38:0] inj,
    input logic        csb,
    input logic        web
  );
    @(negedge clk);
    A2 = a; I2 = d; ERR_INJ = inj;
    CSB2 = csb; WEB2 = web; CE2 = 1'b1;
    @(negedge clk);
    CE2 = 1'b0; CSB2 = 1'b1; WEB2 = 1'b1;
    ERR_INJ = '0;
  endtask

  task automatic do_read(input logic [9:0] a);
    @(negedge clk);
    A1 = a; CSB1 = 1'b0; CE1 = 1'b1;
    @(negedge clk);
    CE1 = 1'b0; CSB1 = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    total_cnt++;
    if (O1 !== 32'd0)
      $display("FAIL reset_O1 got %h want 0", O1);
    else pass_cnt++;
    total_cnt++;
    if ({SEC_ERR, DED_ERR} !== 2'b00)
      $display("FAIL reset_flags got %b want 00",
               {SEC_ERR, DED_ERR});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    do_write(10'd4, 32'd454, '0, 1'b0, 1'b0);
    do_read(10'd4);
    total_cnt++;
    if (O1 !== 32'd454)
      $display("FAIL rd4 got %0d want 454", O1);
    else pass_cnt++;
    total_cnt++;
    if ({SEC_ERR, DED_ERR} !== 2'b00)
      $display("FAIL rd4_flags got %b want 00",
               {SEC_ERR, DED_ERR});
    else pass_cnt++;
    do_write(10'd11, 32'd898, '0, 1'b0, 1'b0);
    do_read(10'd11);
    total_cnt++;
    if (O1 !== 32'd898)
      $display("FAIL rd11 got %0d want 898", O1);
    else pass_cnt++;
    do_read(10'd4);
    total_cnt++;
    if (O1 !== 32'd454)
      $display("FAIL rd4_again got %0d want 454", O1);
    else pass_cnt++;
  endtask

  task automatic test_blocked_write;
    do_write(10'd4, 32'hDEAD_BEEF, '0, 1'b1, 1'b0);
    do_write(10'd4, 32'h1234_5678, '0, 1'b0, 1'b1);
    do_read(10'd11);
    do_read(10'd4);
    total_cnt++;
    if (O1 !== 32'd454)
      $display("FAIL blocked_wr got %0d want 454", O1);
    else pass_cnt++;
    OEB1 = 1'b1;
    #1;
    total_cnt++;
    if (O1 !== 32'd0)
      $display("FAIL oeb_gate got %h want 0", O1);
    else pass_cnt++;
    OEB1 = 1'b0;
    #1;
    total_cnt++;
    if (O1 !== 32'd454)
      $display("FAIL oeb_restore got %0d want 454", O1);
    else pass_cnt++;
  endtask

  task automatic test_hold;
    // CSB1 high on a CE1 rise: output holds
    @(negedge clk);
    A1 = 10'd11; CSB1 = 1'b1; CE1 = 1'b1;
    @(negedge clk);
    CE1 = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (O1 !== 32'd454)
      $display("FAIL hold got %0d want 454", O1);
    else pass_cnt++;
  endtask

  task automatic test_sec;
    logic [38:0] inj;
    inj = '0;
    inj[5] = 1'b1;
    do_write(10'd7, 32'hA5A5_A5A5, inj, 1'b0, 1'b0);
    do_read(10'd7);
    total_cnt++;
    if (O1 !== 32'hA5A5_A5A5)
      $display("FAIL sec_data got %h want a5a5a5a5", O1);
    else pass_cnt++;
    total_cnt++;
    if ({SEC_ERR, DED_ERR} !== 2'b10)
      $display("FAIL sec_flags got %b want 10",
               {SEC_ERR, DED_ERR});
    else pass_cnt++;
  endtask

  task automatic test_ded;
    logic [38:0] inj;
    inj = '0;
    inj[3]  = 1'b1;
    inj[20] = 1'b1;
    do_write(10'd8, 32'h1234_5678, inj, 1'b0, 1'b0);
    do_read(10'd8);
    total_cnt++;
    if ({SEC_ERR, DED_ERR} !== 2'b01)
      $display("FAIL ded_flags got %b want 01",
               {SEC_ERR, DED_ERR});
    else pass_cnt++;
    // position 21 carries d15; data left uncorrected
    total_cnt++;
    if (O1 !== 32'h1234_D678)
      $display("FAIL ded_data got %h want 1234d678", O1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    // same-edge read and write to 11
    @(negedge clk);
    A1 = 10'd11; CSB1 = 1'b0; CE1 = 1'b1;
    A2 = 10'd11; I2 = 32'd777; ERR_INJ = '0;
    CSB2 = 1'b0; WEB2 = 1'b0; CE2 = 1'b1;
    @(negedge clk);
    CE1 = 1'b0; CSB1 = 1'b1;
    CE2 = 1'b0; CSB2 = 1'b1; WEB2 = 1'b1;
    total_cnt++;
    if (O1 !== 32'd898)
      $display("FAIL rbw_old got %0d want 898", O1);
    else pass_cnt++;
    total_cnt++;
    if ({SEC_ERR, DED_ERR} !== 2'b00)
      $display("FAIL rbw_flags got %b want 00",
               {SEC_ERR, DED_ERR});
    else pass_cnt++;
    do_read(10'd11);
    total_cnt++;
    if (O1 !== 32'd777)
      $display("FAIL rbw_new got %0d want 777", O1);
    else pass_cnt++;
  endtask

  task automatic test_async_reset;
    do_read(10'd8);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (O1 !== 32'd0)
      $display("FAIL areset_O1 got %h want 0", O1);
    else pass_cnt++;
    total_cnt++;
    if ({SEC_ERR, DED_ERR} !== 2'b00)
      $display("FAIL areset_flags got %b want 00",
               {SEC_ERR, DED_ERR});
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_read(10'd4);
    total_cnt++;
    if (O1 !== 32'd454)
      $display("FAIL post_reset got %0d want 454", O1);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst_n = 1'b0;
    CE1 = 1'b0; CSB1 = 1'b1; OEB1 = 1'b0; A1 = '0;
    CE2 = 1'b0; CSB2 = 1'b1; WEB2 = 1'b1;
    A2 = '0; I2 = '0; ERR_INJ = '0;
    test_reset;
    test_basic;
    test_blocked_write;
    test_hold;
    test_sec;
    test_ded;
    test_back_to_back;
    test_async_reset;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
